// File: rtl/random_range_fifo_if.sv
// Bundle of sample-input, range-limit and FWFT-output signals for random_range_fifo.
// reject_count is present only when RANDOM_RANGE_STATS_EN is defined.
interface random_range_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] rnd_in;
    logic             enable;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [LW-1:0]    level;
    logic             src_stuck;
`ifdef RANDOM_RANGE_STATS_EN
    logic [15:0]      reject_count;
`endif

    // master: LFSR source plus downstream consumer
    modport master (
`ifdef RANDOM_RANGE_STATS_EN
        input  reject_count,
`endif
        output rnd_in, enable, limit, out_ready,
        input  out_data, out_valid, level, src_stuck
    );

    modport slave (
`ifdef RANDOM_RANGE_STATS_EN
        output reject_count,
`endif
        input  rnd_in, enable, limit, out_ready,
        output out_data, out_valid, level, src_stuck
    );
endinterface

// File: rtl/random_range_fifo.sv
// Mask-and-reject range reduction of LFSR samples into an FWFT FIFO, with stuck-source detection.
// Optional reject statistics counter enabled by defining RANDOM_RANGE_STATS_EN.
module random_range_fifo #(
    parameter int DEPTH        = 8,
    parameter int WIDTH        = 8,
    parameter int STUCK_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    random_range_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(STUCK_CYCLES + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] head_reg, head_next;

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cand;
    logic             full;
    logic             empty;
    logic             reject;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] prev_reg;
    logic [SW-1:0]    stuck_cnt_reg, stuck_cnt_next;
    logic             src_stuck_reg;

    // Smear limit's top set bit downward to get the smallest all-ones mask covering it
    always_comb begin
        mask = bus.limit;
        for (int i = 1; i < WIDTH; i++) begin
            mask = mask | (bus.limit >> i);
        end
    end

    assign cand   = bus.rnd_in & mask;
    assign full   = (count_reg == LW'(DEPTH));
    assign empty  = (count_reg == '0);
    assign reject = bus.enable && (cand > bus.limit);
    assign push   = bus.enable && !reject && !full;
    assign pop    = !empty && bus.out_ready;

    always_comb begin
        wr_ptr_next = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        count_next  = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
        // Bypass the RAM when the new head is the entry being written this edge
        head_next = (push && (wr_ptr_reg == rd_ptr_next)) ? cand : mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= cand;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

    always_comb begin
        stuck_cnt_next = '0;
        if (bus.rnd_in == prev_reg) begin
            stuck_cnt_next = (stuck_cnt_reg == SW'(STUCK_CYCLES)) ? stuck_cnt_reg
                                                                 : stuck_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_reg      <= '0;
            stuck_cnt_reg <= '0;
            src_stuck_reg <= 1'b0;
        end else begin
            prev_reg      <= bus.rnd_in;
            stuck_cnt_reg <= stuck_cnt_next;
            src_stuck_reg <= (stuck_cnt_next == SW'(STUCK_CYCLES));
        end
    end

`ifdef RANDOM_RANGE_STATS_EN
    logic [15:0] reject_count_reg;

    // Full-FIFO drops are not rejects and are deliberately not counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reject_count_reg <= '0;
        end else if (reject && (reject_count_reg != 16'hFFFF)) begin
            reject_count_reg <= reject_count_reg + 16'd1;
        end
    end

    assign bus.reject_count = reject_count_reg;
`endif

    assign bus.out_data  = head_reg;
    assign bus.out_valid = !empty;
    assign bus.level     = count_reg;
    assign bus.src_stuck = src_stuck_reg;
endmodule

// File: tb/tb_random_range_fifo.sv
// Directed bench for random_range_fifo: reset, range rejection, fill/drop, push-pop, stuck detect.
// Reject-count checks are compiled in when RANDOM_RANGE_STATS_EN is defined.
module tb_random_range_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    random_range_fifo_if #(.WIDTH(8), .DEPTH(8)) bus();

    random_range_fifo #(.DEPTH(8), .WIDTH(8), .STUCK_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic [7:0] rnd);
        bus.rnd_in = rnd;
        step();
        $display("xact rnd=%02h en=%0b lim=%02h rdy=%0b -> level=%0d valid=%0b data=%02h stuck=%0b",
                 rnd, bus.enable, bus.limit, bus.out_ready, bus.level, bus.out_valid,
                 bus.out_data, bus.src_stuck);
    endtask

    task automatic test_reset();
        bus.rnd_in = 8'h00; bus.enable = 1'b0; bus.limit = 8'h00; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h want 00", bus.out_data); end
        checks++; if (bus.src_stuck !== 1'b0) begin errors++; $display("FAIL reset_stuck: got %0b want 0", bus.src_stuck); end
`ifdef RANDOM_RANGE_STATS_EN
        checks++; if (bus.reject_count !== 16'd0) begin errors++; $display("FAIL reset_rejcnt: got %0d want 0", bus.reject_count); end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_range();
        bus.limit = 8'd9; bus.out_ready = 1'b0; bus.enable = 1'b1;
        xact(8'h23);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h03) begin errors++; $display("FAIL range_first: got valid=%0b data=%02h want valid=1 data=03", bus.out_valid, bus.out_data); end
        xact(8'h1C);
        checks++; if (bus.level !== 4'd1) begin errors++; $display("FAIL range_reject_level: got %0d want 1", bus.level); end
        xact(8'h05);
        bus.enable = 1'b0;
        checks++; if (bus.level !== 4'd2 || bus.out_data !== 8'h03) begin errors++; $display("FAIL range_queued: got level=%0d data=%02h want level=2 data=03", bus.level, bus.out_data); end
`ifdef RANDOM_RANGE_STATS_EN
        checks++; if (bus.reject_count !== 16'd1) begin errors++; $display("FAIL range_rejcnt: got %0d want 1", bus.reject_count); end
`endif
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.level !== 4'd1 || bus.out_data !== 8'h05) begin errors++; $display("FAIL range_pop1: got level=%0d data=%02h want level=1 data=05", bus.level, bus.out_data); end
        step();
        checks++; if (bus.level !== 4'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL range_pop2: got level=%0d valid=%0b want level=0 valid=0", bus.level, bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_fill();
        bus.limit = 8'hFF; bus.out_ready = 1'b0; bus.enable = 1'b1;
        for (int i = 0; i < 10; i++) xact(8'hA0 + 8'(i));
        bus.enable = 1'b0;
        checks++; if (bus.level !== 4'd8 || bus.out_data !== 8'hA0) begin errors++; $display("FAIL fill_full: got level=%0d data=%02h want level=8 data=a0", bus.level, bus.out_data); end
`ifdef RANDOM_RANGE_STATS_EN
        checks++; if (bus.reject_count !== 16'd1) begin errors++; $display("FAIL fill_rejcnt: got %0d want 1", bus.reject_count); end
`endif
    endtask

    task automatic test_full_push_pop();
        bus.enable = 1'b1; bus.out_ready = 1'b1;
        xact(8'h55);
        bus.enable = 1'b0;
        checks++; if (bus.level !== 4'd7 || bus.out_data !== 8'hA1) begin errors++; $display("FAIL full_pushpop: got level=%0d data=%02h want level=7 data=a1", bus.level, bus.out_data); end
        for (int i = 1; i < 8; i++) begin
            checks++; if (bus.out_data !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL drain_order[%0d]: got %02h want %02h", i, bus.out_data, 8'hA0 + 8'(i)); end
            step();
        end
        checks++; if (bus.level !== 4'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got level=%0d valid=%0b want level=0 valid=0", bus.level, bus.out_valid); end
    endtask

    task automatic test_empty_pop();
        bus.enable = 1'b0; bus.out_ready = 1'b1;
        step(); step();
        checks++; if (bus.level !== 4'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL empty_pop: got level=%0d valid=%0b want level=0 valid=0", bus.level, bus.out_valid); end
        bus.enable = 1'b1; bus.limit = 8'hFF;
        xact(8'h3C);
        bus.enable = 1'b0;
        checks++; if (bus.level !== 4'd1 || bus.out_data !== 8'h3C) begin errors++; $display("FAIL after_underflow: got level=%0d data=%02h want level=1 data=3c", bus.level, bus.out_data); end
        step();
        checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL after_underflow_pop: got %0d want 0", bus.level); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_push_pop_order();
        bus.limit = 8'hFF; bus.out_ready = 1'b0; bus.enable = 1'b1;
        xact(8'h11);
        xact(8'h22);
        bus.out_ready = 1'b1;
        xact(8'h33);
        bus.enable = 1'b0;
        checks++; if (bus.level !== 4'd2 || bus.out_data !== 8'h22) begin errors++; $display("FAIL pushpop_mid: got level=%0d data=%02h want level=2 data=22", bus.level, bus.out_data); end
        step();
        checks++; if (bus.level !== 4'd1 || bus.out_data !== 8'h33) begin errors++; $display("FAIL pushpop_tail: got level=%0d data=%02h want level=1 data=33", bus.level, bus.out_data); end
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.limit = 8'h00; bus.enable = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            xact(8'hFF);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00 || bus.level !== 4'd1) begin errors++; $display("FAIL b2b[%0d]: got valid=%0b data=%02h level=%0d want valid=1 data=00 level=1", i, bus.out_valid, bus.out_data, bus.level); end
        end
        bus.enable = 1'b0;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stuck();
        bus.enable = 1'b0;
        repeat (8) xact(8'h00);
        checks++; if (bus.src_stuck !== 1'b0) begin errors++; $display("FAIL stuck_early: got %0b want 0", bus.src_stuck); end
        repeat (12) xact(8'h00);
        checks++; if (bus.src_stuck !== 1'b1) begin errors++; $display("FAIL stuck_set: got %0b want 1", bus.src_stuck); end
        xact(8'h01);
        checks++; if (bus.src_stuck !== 1'b0) begin errors++; $display("FAIL stuck_clear: got %0b want 0", bus.src_stuck); end
    endtask

    task automatic test_reset_mid();
        bus.limit = 8'hFF; bus.enable = 1'b1; bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) xact(8'h60 + 8'(i));
        checks++; if (bus.level !== 4'd5) begin errors++; $display("FAIL mid_queued: got %0d want 5", bus.level); end
        bus.enable = 1'b0;
        rst = 1'b1;
        #2;
        checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL mid_async: got %0d want 0", bus.level); end
        step();
        checks++; if (bus.level !== 4'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset: got level=%0d valid=%0b want level=0 valid=0", bus.level, bus.out_valid); end
`ifdef RANDOM_RANGE_STATS_EN
        checks++; if (bus.reject_count !== 16'd0) begin errors++; $display("FAIL mid_rejcnt: got %0d want 0", bus.reject_count); end
`endif
        rst = 1'b0;
        step();
        checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL mid_after: got %0d want 0", bus.level); end
    endtask

    initial begin
        test_reset();
        test_range();
        test_fill();
        test_full_push_pop();
        test_empty_pop();
        test_push_pop_order();
        test_back_to_back();
        test_stuck();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
